// File: rtl/bp_cce_dir_arbiter.sv
// rtl/bp_cce_dir_arbiter.sv - CCE directory port arbiter between microcode and message unit
module bp_cce_dir_arbiter #(
  parameter int max_wait_p  = 16,
  parameter int cnt_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   ucode_v_i,
  output logic                   ucode_gnt_o,
  input  logic                   msg_v_i,
  input  logic                   msg_lock_i,
  output logic                   msg_gnt_o,
  input  logic                   dir_busy_i,
  output logic                   dir_v_o,
  output logic                   dir_sel_o,
  output logic                   msg_dir_w_busy_o,
  input  logic                   clr_stall_cnt_i,
  output logic [cnt_width_p-1:0] starve_count_o
);

  localparam int wait_width_lp = $clog2(max_wait_p + 1);
  localparam logic [wait_width_lp-1:0] wait_max_lp = wait_width_lp'(max_wait_p);
  localparam logic [cnt_width_p-1:0]   starve_max_lp = '1;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_lock  = 2'd1,
    e_yield = 2'd2
  } state_e;

  state_e                   state_r, state_n;
  logic [wait_width_lp-1:0] wait_cnt_r, wait_cnt_n;
  logic                     wait_sat;
  logic                     ucode_denied;

  assign wait_sat     = (wait_cnt_r == wait_max_lp);
  assign ucode_denied = ucode_v_i & ~ucode_gnt_o;

  // Grant selection: a starved microcode request beats the message unit in idle
  always_comb begin
    ucode_gnt_o = 1'b0;
    msg_gnt_o   = 1'b0;
    if (!reset_i && !dir_busy_i) begin
      unique case (state_r)
        e_idle: begin
          if (wait_sat && ucode_v_i) ucode_gnt_o = 1'b1;
          else if (msg_v_i)          msg_gnt_o   = 1'b1;
          else if (ucode_v_i)        ucode_gnt_o = 1'b1;
        end
        e_lock:  msg_gnt_o   = msg_v_i;
        e_yield: ucode_gnt_o = ucode_v_i;
        default: ;
      endcase
    end
  end

  assign dir_v_o          = ucode_gnt_o | msg_gnt_o;
  assign dir_sel_o        = msg_gnt_o;
  assign msg_dir_w_busy_o = ~reset_i & (msg_gnt_o | (state_r == e_lock));

  // Next wait count and next state; a busy directory freezes the state
  always_comb begin
    if (ucode_gnt_o)                 wait_cnt_n = '0;
    else if (ucode_v_i && !wait_sat) wait_cnt_n = wait_cnt_r + 1'b1;
    else                             wait_cnt_n = wait_cnt_r;

    state_n = state_r;
    if (!dir_busy_i) begin
      unique case (state_r)
        e_idle:  if (msg_gnt_o && msg_lock_i) state_n = e_lock;
        e_lock: begin
          if (!msg_lock_i)                     state_n = e_idle;
          else if (wait_cnt_n == wait_max_lp)  state_n = e_yield;
        end
        e_yield: state_n = msg_lock_i ? e_lock : e_idle;
        default: state_n = e_idle;
      endcase
    end
  end

  // State, bounded-wait counter and saturating starvation statistic
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= e_idle;
      wait_cnt_r     <= '0;
      starve_count_o <= '0;
    end else begin
      state_r <= state_n;
      // Leaving yield always restarts the wait window, granted or abandoned
      if (state_r == e_yield && !dir_busy_i) wait_cnt_r <= '0;
      else                                    wait_cnt_r <= wait_cnt_n;
      if (clr_stall_cnt_i)
        starve_count_o <= '0;
      else if (ucode_denied && starve_count_o != starve_max_lp)
        starve_count_o <= starve_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_cce_dir_arbiter.sv
// tb/tb_bp_cce_dir_arbiter.sv - randomized self-checking bench for bp_cce_dir_arbiter
module tb_bp_cce_dir_arbiter;

  localparam int MW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_i, ucode_v_i, msg_v_i, msg_lock_i, dir_busy_i, clr_stall_cnt_i;
  logic          ucode_gnt_o, msg_gnt_o, dir_v_o, dir_sel_o, msg_dir_w_busy_o;
  logic [CW-1:0] starve_count_o;

  int checks = 0;
  int errors = 0;

  // model: port mode (0 free, 1 held by message unit, 2 microcode slot owed)
  int m_mode, m_wait, m_starve;
  int exp_ug, exp_mg;
  int ug_seen, mg_seen;

  always #5 clk = ~clk;

  bp_cce_dir_arbiter #(.max_wait_p(MW), .cnt_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .ucode_v_i(ucode_v_i), .ucode_gnt_o(ucode_gnt_o),
    .msg_v_i(msg_v_i), .msg_lock_i(msg_lock_i), .msg_gnt_o(msg_gnt_o),
    .dir_busy_i(dir_busy_i), .dir_v_o(dir_v_o), .dir_sel_o(dir_sel_o),
    .msg_dir_w_busy_o(msg_dir_w_busy_o), .clr_stall_cnt_i(clr_stall_cnt_i),
    .starve_count_o(starve_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, check against model, then advance the model on the edge
  task automatic step(input bit r, input bit uv, input bit mv, input bit ml,
                      input bit db, input bit clr);
    @(negedge clk);
    reset_i = r; ucode_v_i = uv; msg_v_i = mv; msg_lock_i = ml;
    dir_busy_i = db; clr_stall_cnt_i = clr;
    #1;
    exp_ug = 0; exp_mg = 0;
    if (!r && !db) begin
      if (m_mode == 2)      exp_ug = uv;
      else if (m_mode == 1) exp_mg = mv;
      else if (uv && m_wait >= MW) exp_ug = 1;
      else if (mv)          exp_mg = 1;
      else if (uv)          exp_ug = 1;
    end
    check("ucode_gnt", ucode_gnt_o, exp_ug);
    check("msg_gnt", msg_gnt_o, exp_mg);
    check("dir_v", dir_v_o, exp_ug | exp_mg);
    check("dir_sel", dir_sel_o, exp_mg);
    check("busy", msg_dir_w_busy_o, (!r && (exp_mg == 1 || m_mode == 1)) ? 1 : 0);
    check("starve", starve_count_o, m_starve);
    ug_seen += exp_ug; mg_seen += exp_mg;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_wait = 0; m_starve = 0;
    end else begin
      int denied;
      int nw;
      denied = (uv && !exp_ug) ? 1 : 0;
      nw = exp_ug ? 0 : (denied ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : m_wait);
      if (clr) m_starve = 0;
      else if (denied && m_starve < 255) m_starve++;
      m_wait = nw;
      if (!db) begin
        if (m_mode == 2) begin
          m_mode = ml ? 1 : 0;
          m_wait = 0;
        end else if (m_mode == 1) begin
          if (!ml) m_mode = 0;
          else if (nw == MW) m_mode = 2;
        end else if (exp_mg == 1 && ml) begin
          m_mode = 1;
        end
      end
    end
  endtask

  initial begin
    m_mode = 0; m_wait = 0; m_starve = 0; ug_seen = 0; mg_seen = 0;
    reset_i = 1; ucode_v_i = 0; msg_v_i = 0; msg_lock_i = 0; dir_busy_i = 0; clr_stall_cnt_i = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0);

    // microcode alone, then contention without lock
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    #1 check("starve_after_msg_win", starve_count_o, 1);

    // locked burst of 4 beats with a 2-cycle gap, microcode idle
    mg_seen = 0;
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("burst_beats", mg_seen, 4);
    step(0, 1, 0, 0, 0, 0);

    // bounded wait: lock held forever with microcode pending
    step(1, 0, 0, 0, 0, 0);
    ug_seen = 0;
    repeat (4) step(0, 1, 1, 1, 0, 0);
    check("yield_denials", ug_seen, 0);
    step(0, 1, 1, 1, 0, 0);
    check("yield_grant", ug_seen, 1);
    #1 check("yield_starve", starve_count_o, 4);
    mg_seen = 0;
    step(0, 1, 1, 1, 0, 0);
    check("lock_resumes", mg_seen, 1);
    repeat (6) step(0, 1, 1, 1, 0, 0);

    // busy directory with both requesters active
    step(1, 0, 0, 0, 0, 0);
    ug_seen = 0; mg_seen = 0;
    repeat (3) step(0, 1, 1, 0, 1, 0);
    check("busy_no_grants", ug_seen + mg_seen, 0);
    step(0, 1, 1, 0, 0, 0);
    check("busy_resume", mg_seen, 1);

    // saturation then clear alongside a denial
    repeat (260) step(0, 1, 0, 0, 1, 0);
    #1 check("starve_sat", starve_count_o, 255);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1);
    #1 check("starve_clr", starve_count_o, 0);

    // reset in the middle of a lock
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    #1 check("reset_unlocks", msg_dir_w_busy_o, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(2) != 0), ($urandom_range(1) == 1),
           ($urandom_range(3) != 0), ($urandom_range(5) == 0), ($urandom_range(49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_cce_dir_arbiter.md
Name: bp_cce_dir_arbiter

Overview:
- Arbitrates the single CCE directory access port between two requesters: the microcode instruction path and the message unit.
- Microcode requests are single-cycle. The message unit may lock the port for a multi-beat burst, such as an invalidation sequence writing several directory entries.
- The block produces the message-unit directory busy indication consumed by the stall unit, so a denied microcode directory instruction stalls and replays.
- A bounded-wait mechanism guarantees microcode forward progress while the message unit holds a lock.

Parameters:
- max_wait_p, 16: cycles a pending microcode request may be denied before the message lock is forced to yield one slot; legal range 1..255.
- cnt_width_p, 8: width of the saturating starvation statistic counter.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- ucode_v_i  input  1  microcode directory request (read or write) this cycle
- ucode_gnt_o  output  1  microcode owns the port this cycle
- msg_v_i  input  1  message unit directory request (one beat) this cycle
- msg_lock_i  input  1  message unit requests exclusive hold beyond the current beat
- msg_gnt_o  output  1  message unit owns the port this cycle
- dir_busy_i  input  1  directory busy completing a multi-cycle read; no new access allowed
- dir_v_o  output  1  a directory access is issued this cycle (ucode_gnt_o | msg_gnt_o)
- dir_sel_o  output  1  port mux select: 0 = microcode, 1 = message unit
- msg_dir_w_busy_o  output  1  to stall unit: port unavailable to microcode (owned by or locked for the message unit)
- clr_stall_cnt_i  input  1  clear starvation statistic
- starve_count_o  output  cnt_width_p  cycles the microcode was denied, saturating

Behaviour:
- Grants and dir_v_o/dir_sel_o are combinational from inputs and registered state. They are mutually exclusive: at most one grant per cycle.
- In reset cycles all grants, dir_v_o, dir_sel_o and msg_dir_w_busy_o are forced to 0, state returns to IDLE, and all counters clear.
- dir_busy_i=1 in any state: no grant; state holds; wait counter still advances if ucode_v_i=1.
- wait_cnt, internal:
  - width clog2(max_wait_p+1);
  - increments when ucode_v_i & ~ucode_gnt_o; saturates at max_wait_p;
  - clears on ucode_gnt_o.
- State IDLE:
  - If wait_cnt==max_wait_p and ucode_v_i: grant ucode.
  - Else if msg_v_i: grant msg. If msg_lock_i, next state is LOCK.
  - Else if ucode_v_i: grant ucode.
  - Default priority is message unit over microcode.
- State LOCK:
  - msg_gnt_o = msg_v_i; ucode never granted.
  - msg_v_i=0 with msg_lock_i=1 is a legal gap: stay in LOCK.
  - Exit to IDLE when msg_lock_i=0; the beat presented in that cycle, if any, is still granted.
  - If wait_cnt reaches max_wait_p while still locked, next state is YIELD. This takes lower precedence than the exit condition.
- State YIELD:
  - msg never granted.
  - Once ucode_v_i=1 and dir_busy_i=0, grant ucode for exactly one cycle. Next state is LOCK if msg_lock_i=1, else IDLE.
  - If ucode_v_i drops before being granted, return next cycle to LOCK (msg_lock_i=1) or IDLE, and clear wait_cnt.
- msg_dir_w_busy_o = msg_gnt_o | (state==LOCK).
  - YIELD and IDLE without a msg grant report 0, so a pending microcode request does not stall on the message unit.
- starve_count_o:
  - increments when ucode_v_i & ~ucode_gnt_o; saturates at 2^cnt_width_p-1;
  - clr_stall_cnt_i has priority over increment;
  - registered, 0 after reset.
- A simultaneous msg_lock_i deassert and yield threshold resolves to IDLE. Microcode then wins in IDLE via the saturated wait_cnt.
- Reset mid-lock abandons the burst; the message unit must re-request.

Test Plan:
- Reset, then ucode_v_i=1 alone: ucode_gnt_o=1, dir_sel_o=0, dir_v_o=1, msg_dir_w_busy_o=0, starve_count_o=0.
- ucode_v_i=1 and msg_v_i=1 (no lock) in the same cycle from IDLE: msg_gnt_o=1, dir_sel_o=1, msg_dir_w_busy_o=1. Next cycle ucode is granted; starve_count_o=1.
- Message lock burst of 4 beats with a 2-cycle msg_v_i gap, microcode idle: 4 msg grants; LOCK held through the gap with msg_dir_w_busy_o=1; IDLE after the cycle with msg_lock_i=0.
- max_wait_p=4, lock held indefinitely, ucode_v_i held:
  - ucode is denied 4 cycles, then YIELD gives exactly 1 ucode grant;
  - the port returns to LOCK, and msg beats resume the following cycle;
  - starve_count_o=4.
- dir_busy_i=1 for 3 cycles with both requesters active: no grants, state unchanged, starve_count_o advances by 3. Grants resume on the first cycle dir_busy_i=0.
- starve_count_o forced to 255 with cnt_width_p=8: stays at 255 while denials continue; clr_stall_cnt_i together with a denial yields 0 the next cycle. Separately, reset asserted while in LOCK: IDLE and all outputs 0 on the following cycle.
